// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock sequencer releasing the system reset after stable lock
//
// Runs entirely on the 12 MHz reference clock. Holds the PLL in reset, waits
// for a synchronised lock, demands a stable lock window, then releases the
// 100 MHz domain. It retries on lock timeout and parks in a sticky fault
// state once the retries are used up.
//
// Ports:
//   REFERENCECLK  in   reference clock, the only clock
//   RESET         in   asynchronous active-low reset
//   LOCK          in   PLL lock, asynchronous to REFERENCECLK
//   PLLRESETB     out  PLL reset, active-low
//   SYSRESETN     out  system reset for the 100 MHz domain, active-low
//   READY         out  high while running with a stable lock
//   FAULT         out  sticky fault, cleared only by RESET
//   RETRIES       out  lock timeouts taken in the current sequence
module pll_reset_sequencer #(
    parameter int unsigned HOLD_CYCLES   = 12,
    parameter int unsigned LOCK_TIMEOUT  = 1200,
    parameter int unsigned STABLE_CYCLES = 120,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       REFERENCECLK,
    input  logic       RESET,
    input  logic       LOCK,
    output logic       PLLRESETB,
    output logic       SYSRESETN,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] RETRIES
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       MAX_R        = 4'(MAX_RETRIES);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [3:0]         retries_nxt;
    logic               lock_m;
    logic               lock_s;

    // Two-flop synchroniser; nothing downstream ever looks at raw LOCK.
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= LOCK;
            lock_s <= lock_m;
        end
    end

    // One shared counter: it runs in the timed states and is zeroed on any
    // state change, so each state measures its own dwell from zero.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        retries_nxt = RETRIES;
        case (state)
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock wins over a timeout landing on the same edge.
                if (lock_s) begin
                    state_nxt = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (RETRIES == MAX_R) begin
                        state_nxt = S_FAULT;
                    end else begin
                        retries_nxt = RETRIES + 1'b1;
                        state_nxt   = S_HOLD;
                    end
                end
            end
            S_STABLE: begin
                // Any drop restarts the lock wait but keeps the retry tally.
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt   = S_RUN;
                    retries_nxt = 4'd0;
                end
            end
            S_RUN: begin
                cnt_nxt = '0;
                if (!lock_s) begin
                    state_nxt = S_HOLD;
                end
            end
            S_FAULT: begin
                cnt_nxt = '0;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_HOLD;
            end
        endcase
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end
    end

    // Outputs are registered from the next-state decode so they switch on
    // the same edge as the state and carry no combinational path from LOCK.
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_HOLD;
            cnt       <= '0;
            RETRIES   <= 4'd0;
            PLLRESETB <= 1'b0;
            SYSRESETN <= 1'b0;
            READY     <= 1'b0;
            FAULT     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            RETRIES   <= retries_nxt;
            PLLRESETB <= (state_nxt != S_HOLD) && (state_nxt != S_FAULT);
            SYSRESETN <= (state_nxt == S_RUN);
            READY     <= (state_nxt == S_RUN);
            FAULT     <= (state_nxt == S_FAULT);
        end
    end

endmodule
